// File: rtl/soc_cpu_1_oci_monitor_mem_if.sv
// Avalon-MM bus bundle for the CPU side of the OCI monitor memory.
//
// Signals:
//   address     word address into the monitor RAM
//   read/write  access requests, held until waitrequest drops
//   writedata   write data
//   byteenable  byte lanes for writes
//   readdata    read data, valid in the cycle waitrequest drops on a read
//   waitrequest stall
//
// Modports: master (CPU / bench), slave (monitor memory).
interface soc_cpu_1_oci_monitor_mem_if #(
  parameter int unsigned ADDR_W = 8
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  readdata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output readdata,
    output waitrequest
  );

endinterface

// File: rtl/soc_cpu_1_oci_monitor_mem.sv
// OCI monitor memory: single-port 32-bit debug RAM that is shared between the
// JTAG debug module (sysclk stage) and the CPU (Avalon-MM slave).
//
// Ports:
//   clk, reset_n               system clock, asynchronous active-low reset
//   take_action_ocimem_a       strobe: load MonAReg from jdo, optional read
//   take_action_ocimem_b       strobe: load MonDReg from jdo, queue write
//   take_no_action_ocimem_a    strobe: read at current MonAReg
//   jdo[37:0]                  JTAG payload, stable during each strobe
//   MonDReg[31:0]              monitor data register back to the TCK stage
//   monitor_ready              last JTAG read completed
//   monitor_error              sticky overrun flag
//   avs                        Avalon-MM slave (see soc_cpu_1_oci_monitor_mem_if)
//
// JTAG ops are accepted into a one-deep pending slot (pend_v/pend_wr) and are
// served ahead of the CPU whenever the FSM is idle. MonAReg auto-increments
// (modulo 2^ADDR_W) after every JTAG RAM access.
module soc_cpu_1_oci_monitor_mem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         take_action_ocimem_a,
  input  logic                         take_action_ocimem_b,
  input  logic                         take_no_action_ocimem_a,
  input  logic [37:0]                  jdo,
  output logic [31:0]                  MonDReg,
  output logic                         monitor_ready,
  output logic                         monitor_error,

  soc_cpu_1_oci_monitor_mem_if.slave   avs
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StJRd  = 2'd1,
    StCRd  = 2'd2
  } state_e;

  localparam int unsigned Depth = 2 ** ADDR_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_wr_q, pend_wr_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [31:0]       readdata_q, readdata_d;

  // RAM port
  logic [31:0]       mem [Depth];
  logic [31:0]       ram_q;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;

  logic              strobe_any;
  logic              cpu_wr_grant;
  logic              cpu_rd_grant;

  // Payload bits outside the address/data/read-flag fields carry nothing here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    pend_v_d   = pend_v_q;
    pend_wr_d  = pend_wr_q;
    ready_d    = ready_q;
    error_d    = error_q;
    readdata_d = readdata_q;

    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = mon_a_q;
    ram_be     = 4'hF;
    ram_wdata  = mon_d_q;

    // Strobe decode. Only one strobe is taken per cycle (a > b > no_action).
    // With an op already pending the strobe is lost and flagged; a pending op
    // can only retire when pend_v_q is set, so the two never touch the same
    // register in one cycle.
    if (strobe_any) begin
      if (pend_v_q) begin
        error_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        mon_a_d = jdo[17+ADDR_W:18];
        ready_d = 1'b0;
        error_d = 1'b0;
        if (jdo[34]) begin
          pend_v_d  = 1'b1;
          pend_wr_d = 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        mon_d_d   = jdo[34:3];
        pend_v_d  = 1'b1;
        pend_wr_d = 1'b1;
      end else begin
        ready_d   = 1'b0;
        pend_v_d  = 1'b1;
        pend_wr_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_v_q) begin
          // JTAG always wins arbitration.
          if (pend_wr_q) begin
            ram_we   = 1'b1;
            mon_a_d  = mon_a_q + ADDR_W'(1);
            pend_v_d = 1'b0;
          end else begin
            ram_re  = 1'b1;
            state_d = StJRd;
          end
        end else if (avs.write) begin
          ram_we    = 1'b1;
          ram_addr  = avs.address;
          ram_be    = avs.byteenable;
          ram_wdata = avs.writedata;
        end else if (avs.read) begin
          ram_re   = 1'b1;
          ram_addr = avs.address;
          state_d  = StCRd;
        end
      end
      StJRd: begin
        mon_d_d  = ram_q;
        ready_d  = 1'b1;
        mon_a_d  = mon_a_q + ADDR_W'(1);
        pend_v_d = 1'b0;
        state_d  = StIdle;
      end
      StCRd: begin
        readdata_d = ram_q;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      pend_v_q   <= 1'b0;
      pend_wr_q  <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      pend_v_q   <= pend_v_d;
      pend_wr_q  <= pend_wr_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      readdata_q <= readdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-port RAM, byte-writable, read latency 1. Contents are not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_q <= mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Write wins when both requests are up, so grant follows the same priority.
  assign cpu_wr_grant = (state_q == StIdle) && !pend_v_q;
  assign cpu_rd_grant = (state_q == StCRd);

  always_comb begin
    avs.waitrequest = 1'b0;
    if (avs.write) begin
      avs.waitrequest = !cpu_wr_grant;
    end else if (avs.read) begin
      avs.waitrequest = !cpu_rd_grant;
    end
  end

  // The RAM output is forwarded in C_RD so readdata is valid in the same cycle
  // waitrequest drops; readdata_q holds it afterwards.
  assign avs.readdata = (state_q == StCRd) ? ram_q : readdata_q;

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
